// File: rtl/occupancy_controller_pkg.sv
// Shared types and constants for the occupancy controller.
// Holds FSM encoding, counter width and the default occupancy limit.
package occupancy_controller_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] DEF_LIMIT = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/occupancy_controller_if.sv
// Four-phase entry/exit handshake bundle.
// The requester side is master, the controller side is slave.
interface occupancy_if;

  logic in_req;
  logic out_req;
  logic in_ack;
  logic in_rej;
  logic out_ack;
  logic out_rej;

  modport master (
    output in_req,
    output out_req,
    input  in_ack,
    input  in_rej,
    input  out_ack,
    input  out_rej
  );

  modport slave (
    input  in_req,
    input  out_req,
    output in_ack,
    output in_rej,
    output out_ack,
    output out_rej
  );

endinterface

// File: rtl/occupancy_controller_counter.sv
// 4-bit up/down occupancy counter with asynchronous clear.
// Bounds are enforced by the controller, never here.
module occ_counter
  import occupancy_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset_b,
  input  logic             up,
  input  logic             down,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_count <= '0;
    end else if (up && !down) begin
      r_count <= r_count + 1'b1;
    end else if (down && !up) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/occupancy_controller.sv
// Arbitrates entry/exit handshakes and steps the occupancy counter.
// Ties alternate between entry and exit; refused requests leave count.
module occupancy_controller
  import occupancy_controller_pkg::*;
#(
  parameter logic [CNT_W-1:0] LIMIT = DEF_LIMIT
) (
  input  logic             clk,
  input  logic             reset_b,
  occupancy_if.slave       bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  state_t r_state;
  state_t w_nxt_state;
  logic   r_gnt_in;
  logic   r_ok;
  logic   r_last_in;
  logic   w_nxt_gnt_in;
  logic   w_nxt_ok;
  logic   w_nxt_last_in;
  logic   w_pick_in;
  logic   w_gnt_req;
  logic   w_up;
  logic   w_down;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= IDLE;
      r_gnt_in  <= 1'b0;
      r_ok      <= 1'b0;
      r_last_in <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_gnt_in  <= w_nxt_gnt_in;
      r_ok      <= w_nxt_ok;
      r_last_in <= w_nxt_last_in;
    end
  end

  // On a tie the side not granted last time wins
  assign w_pick_in = bus.in_req &&
                     (!bus.out_req || !r_last_in);
  assign w_gnt_req = r_gnt_in ? bus.in_req
                              : bus.out_req;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_gnt_in  = r_gnt_in;
    w_nxt_ok      = r_ok;
    w_nxt_last_in = r_last_in;
    w_up          = 1'b0;
    w_down        = 1'b0;
    bus.in_ack    = 1'b0;
    bus.in_rej    = 1'b0;
    bus.out_ack   = 1'b0;
    bus.out_rej   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.in_req || bus.out_req) begin
          w_nxt_state   = STEP;
          w_nxt_gnt_in  = w_pick_in;
          w_nxt_last_in = w_pick_in;
          w_nxt_ok      = w_pick_in ? !full : !empty;
        end
      end
      STEP: begin
        w_nxt_state = DONE;
        w_up        = r_gnt_in && r_ok;
        w_down      = !r_gnt_in && r_ok;
      end
      DONE: begin
        bus.in_ack  = r_gnt_in && r_ok;
        bus.in_rej  = r_gnt_in && !r_ok;
        bus.out_ack = !r_gnt_in && r_ok;
        bus.out_rej = !r_gnt_in && !r_ok;
        if (!w_gnt_req) begin
          w_nxt_state = IDLE;
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  occ_counter u_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .up      (w_up),
    .down    (w_down),
    .count   (count)
  );

  assign full  = (count == LIMIT);
  assign empty = (count == '0);

endmodule

// File: tb/tb_occupancy_controller.sv
// Directed bench for occupancy_controller.
// Expected values are hand-derived from the handshake timing.
module tb_occupancy_controller;
  import occupancy_controller_pkg::*;

  logic       clk;
  logic       reset_b;
  logic [3:0] count;
  logic       full;
  logic       empty;
  int         n_checks;
  int         n_errors;

  occupancy_if bus ();

  occupancy_controller #(.LIMIT(4'd12)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hs(input string tag,
                        input logic ia, input logic ir,
                        input logic oa, input logic orj);
    chk(tag, {4'd0, bus.in_ack, bus.in_rej,
              bus.out_ack, bus.out_rej},
        {4'd0, ia, ir, oa, orj});
  endtask

  task automatic set_req(input bit is_in, input logic v);
    if (is_in) bus.in_req = v;
    else       bus.out_req = v;
  endtask

  // One full handshake; hold keeps req high extra cycles in DONE
  task automatic hs(input bit is_in, input bit ok,
                    input logic [3:0] exp_cnt, input int hold);
    logic ia, ir, oa, orj;
    ia  = is_in && ok;
    ir  = is_in && !ok;
    oa  = !is_in && ok;
    orj = !is_in && !ok;
    @(negedge clk);
    set_req(is_in, 1'b1);
    @(negedge clk);
    chk_hs("step_quiet", 0, 0, 0, 0);
    @(negedge clk);
    chk("done_cnt", {4'd0, count}, {4'd0, exp_cnt});
    chk_hs("done_hs", ia, ir, oa, orj);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_hs("hold_hs", ia, ir, oa, orj);
      chk("hold_cnt", {4'd0, count}, {4'd0, exp_cnt});
    end
    set_req(is_in, 1'b0);
    @(negedge clk);
    chk_hs("drop_hs", 0, 0, 0, 0);
    chk("drop_cnt", {4'd0, count}, {4'd0, exp_cnt});
    chk("drop_idle", {6'd0, dut.r_state}, {6'd0, IDLE});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    chk("rst_cnt", {4'd0, count}, 8'd0);
    chk("rst_fe", {6'd0, full, empty}, 8'd1);
    chk_hs("rst_hs", 0, 0, 0, 0);
    #2;
    reset_b = 1'b1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    bus.in_req  = 1'b0;
    bus.out_req = 1'b0;
    reset_b     = 1'b1;
    #1 reset_b  = 1'b0;
    #1;
    chk("t2_cnt", {4'd0, count}, 8'd0);
    chk("t2_fe", {6'd0, full, empty}, 8'd1);
    chk_hs("t2_hs", 0, 0, 0, 0);
    chk("t2_idle", {6'd0, dut.r_state}, {6'd0, IDLE});
    #10 reset_b = 1'b1;

    for (int k = 1; k <= 3; k++) hs(1'b1, 1'b1, 4'(k), 0);

    pulse_reset();
    @(negedge clk);
    bus.in_req  = 1'b1;
    bus.out_req = 1'b1;
    @(negedge clk);
    chk_hs("tie_step", 0, 0, 0, 0);
    @(negedge clk);
    chk("tie_cnt1", {4'd0, count}, 8'd1);
    chk_hs("tie_in_ack", 1, 0, 0, 0);
    bus.in_req = 1'b0;
    @(negedge clk);
    chk_hs("tie_idle", 0, 0, 0, 0);
    @(negedge clk);
    chk("tie_step2", {4'd0, count}, 8'd1);
    @(negedge clk);
    chk("tie_cnt0", {4'd0, count}, 8'd0);
    chk_hs("tie_out_ack", 0, 0, 1, 0);
    bus.out_req = 1'b0;
    @(negedge clk);
    chk_hs("tie_end", 0, 0, 0, 0);

    for (int k = 1; k <= 12; k++) hs(1'b1, 1'b1, 4'(k), 0);
    chk("fill_full", {6'd0, full, empty}, 8'd2);
    hs(1'b1, 1'b0, 4'd12, 0);
    chk("rej_full", {6'd0, full, empty}, 8'd2);
    hs(1'b0, 1'b1, 4'd11, 0);
    chk("out_nfull", {6'd0, full, empty}, 8'd0);

    pulse_reset();
    hs(1'b0, 1'b0, 4'd0, 2);
    chk("empty_rej", {6'd0, full, empty}, 8'd1);

    for (int k = 1; k <= 4; k++) hs(1'b1, 1'b1, 4'(k), 0);
    @(negedge clk);
    bus.in_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cnt", {4'd0, count}, 8'd5);
    chk_hs("pre_rst_hs", 1, 0, 0, 0);
    #2 reset_b = 1'b0;
    #1;
    chk("mid_rst_cnt", {4'd0, count}, 8'd0);
    chk_hs("mid_rst_hs", 0, 0, 0, 0);
    bus.in_req = 1'b0;
    #2 reset_b = 1'b1;
    hs(1'b1, 1'b1, 4'd1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/occupancy_controller.md
OCCUPANCY_CONTROLLER -- requirements
Module: occupancy_controller

Interface
REQ-001 Parameter SHALL be: LIMIT, default 4'd12, maximum count (1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_b  input  1  asynchronous, active-low reset.
REQ-004 in_req  input  1  entry request, four-phase; held high until in_ack or in_rej seen.
REQ-005 out_req  input  1  exit request, four-phase; held high until out_ack or out_rej seen.
REQ-006 in_ack / out_ack  output  1 each  request served, count changed.
REQ-007 in_rej / out_rej  output  1 each  request refused, count unchanged.
REQ-008 count  output  4  current occupancy, from internal counter.
REQ-009 full / empty  output  1 each  count==LIMIT / count==0, combinational from count.

Function
REQ-010 FSM states SHALL be IDLE, STEP, DONE; encoding is free.
REQ-011 In IDLE with exactly one request high at an edge: grant that requester, go to STEP.
REQ-012 In IDLE with both requests high: grant the requester not granted last (reg last_in), go to STEP; the loser waits in IDLE with its request held.
REQ-013 At the grant edge, result SHALL be captured: ok=0 if in-grant and full, or out-grant and empty; else ok=1.
REQ-014 In STEP: counter up=1 (in-grant, ok) or down=1 (out-grant, ok) for exactly one cycle; count changes at the STEP->DONE edge.
REQ-015 STEP SHALL always go to DONE after one cycle.
REQ-016 In DONE: the granted requester's ack (ok=1) or rej (ok=0) SHALL be high; other handshake outputs low.
REQ-017 DONE SHALL return to IDLE on the first edge where the granted request is low; ack/rej drop with it.
REQ-018 Latency: request sampled at edge N -> count updated at N+1 -> ack/rej high from N+1 until the edge after req falls.
REQ-019 A request already low in IDLE SHALL never be granted; a request dropped early in STEP SHALL still complete its count update.
REQ-020 count SHALL never exceed LIMIT nor go below 0 (no wrap-around); up and down SHALL never be high together.
REQ-021 last_in SHALL update on every grant, including rejected ones.
REQ-022 Non-granted ack/rej outputs SHALL be 0 in every state.

Reset
REQ-023 reset_b low SHALL force IDLE, count=0, last_in=0 (first tie goes to entry), ok=0, all ack/rej=0, up=down=0; empty=1, full=0.
REQ-024 Reset mid-transaction SHALL abandon it with no count change beyond the one already clocked.

Structure
REQ-025 Shared package SHALL hold: state encoding constants, default LIMIT, count width (4).
REQ-026 One sub-module occ_counter SHALL hold the 4-bit up/down counter (inputs up, down, clk, reset_b).
    - up-only increments; down-only decrements; otherwise holds.
    - asynchronous clear to 0.
REQ-027 occupancy_controller SHALL drive occ_counter only through up/down; estimated 150-250 RTL lines total.

Verification
REQ-028 Reset at t=2 -> count=0, empty=1, all ack/rej=0, FSM IDLE.
REQ-029 Three single in_req handshakes -> count 1,2,3; each in_ack high one edge after STEP; never two-cycle up.
REQ-030 Both req high from IDLE after reset -> entry granted first (count 0->1, in_ack); then exit granted (count 1->0, out_ack).
REQ-031 Fill to LIMIT=12 then in_req -> in_rej, count stays 12, full=1; then out_req -> out_ack, count=11.
REQ-032 out_req at count=0 -> out_rej, count stays 0, empty=1; ack held until out_req drops, IDLE on the next edge.
REQ-033 reset_b pulsed low while in DONE at count=5 -> count=0, in_ack low immediately; a new in_req after release -> count=1.
